packet_injector: RTL and testbench

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/noc_flit_pkg.sv | 47 ++++
 rtl/credit_counter.sv | 43 ++++
 rtl/packet_injector.sv | 171 +++++++++++++++++
 tb/tb_packet_injector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: flit type codes, field placement and the injector state enum.
// Also imported by the sink monitor so both ends agree on the flit layout.
package noc_flit_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } inj_state_e;

  localparam int FLIT_W   = 32;
  localparam int TYPE_LSB = 30;
  localparam int TYPE_W   = 2;
  localparam int DST_LSB  = 24;
  localparam int SRC_LSB  = 18;
  localparam int ID_W     = 6;
  localparam int PKT_LSB  = 8;
  localparam int PKT_W    = 10;
  localparam int IDX_LSB  = 0;
  localparam int IDX_W    = 8;

  function automatic logic [FLIT_W-1:0] build_flit(
    input flit_type_e       ftype,
    input logic [ID_W-1:0]  dst,
    input logic [ID_W-1:0]  src,
    input logic [PKT_W-1:0] pkt,
    input logic [IDX_W-1:0] idx
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[TYPE_LSB +: TYPE_W] = ftype;
    f[DST_LSB  +: ID_W]   = dst;
    f[SRC_LSB  +: ID_W]   = src;
    f[PKT_LSB  +: PKT_W]  = pkt;
    f[IDX_LSB  +: IDX_W]  = idx;
    return f;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream credit tracker: one credit consumed per sent flit, one returned per update.
// A return while already full saturates and flags an overflow for that cycle.
module credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               inc,
  input  logic                               dec,
  output logic [$clog2(CREDITS+1)-1:0]       cnt,
  output logic                               ovf
);

  localparam int            CW   = $clog2(CREDITS+1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == FULL) begin
        ovf = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= FULL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/packet_injector.sv
// Credit-flow-controlled NoC traffic generator: emits bursts of fixed-length packets
// with configurable inter-packet gaps, and flags protocol errors on the downstream link.
//
// state   | meaning
// IDLE    | waiting for start, config registers hold last burst
// SEND    | emitting flits whenever a credit is available
// GAP     | idle cycles between packets, down-counter to terminal count 1
// FIN     | one-cycle done pulse, then back to IDLE
module packet_injector
  import noc_flit_pkg::*;
#(
  parameter int         DW      = 32,
  parameter int         CREDITS = 4,
  parameter logic [5:0] SRC_ID  = 6'd0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [15:0]                  num_pkts,
  input  logic [7:0]                   pkt_len,
  input  logic [5:0]                   dst_id,
  input  logic [7:0]                   gap,
  output logic                         valid,
  output logic [DW-1:0]                data,
  input  logic                         ready,
  input  logic                         credit_upd,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  flits_sent,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic [1:0]                   err
);

  inj_state_e  state_q, state_d;
  logic [15:0] num_pkts_q, num_pkts_d;
  logic [7:0]  pkt_len_q, pkt_len_d;
  logic [5:0]  dst_q, dst_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] pkt_num_q, pkt_num_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] flits_sent_q, flits_sent_d;
  logic [1:0]  err_q, err_d;

  logic        ovf;
  logic [7:0]  len_eff;
  logic        last_flit;
  flit_type_e  ftype;
  logic [31:0] flit;

  credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk  (clk),
    .rstn (rstn),
    .inc  (credit_upd),
    .dec  (valid),
    .cnt  (credit_cnt),
    .ovf  (ovf)
  );

  // valid depends only on registered state, never on ready/credit_upd
  assign valid     = (state_q == ST_SEND) && (credit_cnt != '0);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign len_eff   = (pkt_len_q == 8'd0) ? 8'd1 : pkt_len_q;
  assign last_flit = (idx_q == len_eff - 8'd1);

  always_comb begin
    ftype = FT_BODY;
    if (idx_q == 8'd0) begin
      ftype = (len_eff == 8'd1) ? FT_SINGLE : FT_HEAD;
    end else if (last_flit) begin
      ftype = FT_TAIL;
    end
  end

  assign flit = build_flit(ftype, dst_q, SRC_ID, pkt_num_q[9:0], idx_q);

  always_comb begin
    data = '0;
    if (valid) begin
      data[31:0] = flit;
    end
  end

  always_comb begin
    state_d      = state_q;
    num_pkts_d   = num_pkts_q;
    pkt_len_d    = pkt_len_q;
    dst_d        = dst_q;
    gap_d        = gap_q;
    pkt_num_d    = pkt_num_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    flits_sent_d = flits_sent_q + {31'd0, valid};
    err_d        = err_q | {ovf, valid & ~ready};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_pkts_d = num_pkts;
          pkt_len_d  = pkt_len;
          dst_d      = dst_id;
          gap_d      = gap;
          pkt_num_d  = '0;
          idx_d      = '0;
          state_d    = (num_pkts == 16'd0) ? ST_FIN : ST_SEND;
        end
      end
      ST_SEND: begin
        if (valid) begin
          if (last_flit) begin
            pkt_num_d = pkt_num_q + 16'd1;
            idx_d     = '0;
            if (pkt_num_q == num_pkts_q - 16'd1) begin
              state_d = ST_FIN;
            end else if (gap_q != 8'd0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          gap_cnt_d = '0;
          state_d   = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      num_pkts_q   <= '0;
      pkt_len_q    <= '0;
      dst_q        <= '0;
      gap_q        <= '0;
      pkt_num_q    <= '0;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      flits_sent_q <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      num_pkts_q   <= num_pkts_d;
      pkt_len_q    <= pkt_len_d;
      dst_q        <= dst_d;
      gap_q        <= gap_d;
      pkt_num_q    <= pkt_num_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      flits_sent_q <= flits_sent_d;
      err_q        <= err_d;
    end
  end

  assign flits_sent = flits_sent_q;
  assign err        = err_q;

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector: a per-cycle vector table for the credit-starved
// burst, then hand-written sequences for gaps, reset abandonment and edge configs.
module tb_packet_injector;

  localparam logic [5:0] SRC = 6'h2A;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] num_pkts;
  logic [7:0]  pkt_len;
  logic [5:0]  dst_id;
  logic [7:0]  gap;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic        credit_upd;
  logic        busy;
  logic        done;
  logic [31:0] flits_sent;
  logic [2:0]  credit_cnt;
  logic [1:0]  err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  packet_injector #(.DW(32), .CREDITS(4), .SRC_ID(SRC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .num_pkts   (num_pkts),
    .pkt_len    (pkt_len),
    .dst_id     (dst_id),
    .gap        (gap),
    .valid      (valid),
    .data       (data),
    .ready      (ready),
    .credit_upd (credit_upd),
    .busy       (busy),
    .done       (done),
    .flits_sent (flits_sent),
    .credit_cnt (credit_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        upd;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_done;
    logic [2:0]  e_cnt;
    logic [31:0] e_flits;
    logic [1:0]  e_err;
  } vec_t;

  function automatic logic [31:0] mkflit(input logic [1:0] t, input logic [5:0] d,
                                         input logic [9:0] p, input logic [7:0] i);
    return {t, d, SRC, p, i};
  endfunction

  function automatic vec_t v(input logic s, input logic u, input logic ev, input logic [31:0] ed,
                             input logic eb, input logic edn, input logic [2:0] ec,
                             input logic [31:0] ef, input logic [1:0] ee);
    vec_t r;
    r.start = s; r.upd = u; r.e_valid = ev; r.e_data = ed; r.e_busy = eb;
    r.e_done = edn; r.e_cnt = ec; r.e_flits = ef; r.e_err = ee;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  vec_t tbl[17];
  int   vcyc[$];
  logic [31:0] vdat[$];
  logic seen_done;

  initial begin
    rstn = 1'b0; start = 1'b0; num_pkts = '0; pkt_len = '0; dst_id = '0; gap = '0;
    ready = 1'b1; credit_upd = 1'b0;
    tick();
    tick();
    chk("reset_state", {valid, data, busy, done, credit_cnt, flits_sent, err},
        {1'b0, 32'h0, 1'b0, 1'b0, 3'd4, 32'd0, 2'b00});
    rstn = 1'b1;

    // One 8-flit packet with only 4 credits, then credits trickle back
    tbl[0]  = v(1, 0, 1, mkflit(2'b01, 6'h15, 10'd0, 8'd0), 1, 0, 3'd4, 32'd0, 2'b00);
    tbl[1]  = v(0, 0, 1, mkflit(2'b00, 6'h15, 10'd0, 8'd1), 1, 0, 3'd3, 32'd1, 2'b00);
    tbl[2]  = v(0, 0, 1, mkflit(2'b00, 6'h15, 10'd0, 8'd2), 1, 0, 3'd2, 32'd2, 2'b00);
    tbl[3]  = v(0, 0, 1, mkflit(2'b00, 6'h15, 10'd0, 8'd3), 1, 0, 3'd1, 32'd3, 2'b00);
    tbl[4]  = v(0, 0, 0, 32'h0,                             1, 0, 3'd0, 32'd4, 2'b00);
    tbl[5]  = v(0, 0, 0, 32'h0,                             1, 0, 3'd0, 32'd4, 2'b00);
    tbl[6]  = v(0, 1, 1, mkflit(2'b00, 6'h15, 10'd0, 8'd4), 1, 0, 3'd1, 32'd4, 2'b00);
    tbl[7]  = v(0, 1, 1, mkflit(2'b00, 6'h15, 10'd0, 8'd5), 1, 0, 3'd1, 32'd5, 2'b00);
    tbl[8]  = v(0, 1, 1, mkflit(2'b00, 6'h15, 10'd0, 8'd6), 1, 0, 3'd1, 32'd6, 2'b00);
    tbl[9]  = v(0, 1, 1, mkflit(2'b10, 6'h15, 10'd0, 8'd7), 1, 0, 3'd1, 32'd7, 2'b00);
    tbl[10] = v(0, 0, 0, 32'h0,                             1, 1, 3'd0, 32'd8, 2'b00);
    tbl[11] = v(0, 0, 0, 32'h0,                             0, 0, 3'd0, 32'd8, 2'b00);
    tbl[12] = v(0, 1, 0, 32'h0,                             0, 0, 3'd1, 32'd8, 2'b00);
    tbl[13] = v(0, 1, 0, 32'h0,                             0, 0, 3'd2, 32'd8, 2'b00);
    tbl[14] = v(0, 1, 0, 32'h0,                             0, 0, 3'd3, 32'd8, 2'b00);
    tbl[15] = v(0, 1, 0, 32'h0,                             0, 0, 3'd4, 32'd8, 2'b00);
    tbl[16] = v(0, 1, 0, 32'h0,                             0, 0, 3'd4, 32'd8, 2'b10);

    num_pkts = 16'd1; pkt_len = 8'd8; dst_id = 6'h15; gap = 8'd0;
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start;
      credit_upd = tbl[i].upd;
      tick();
      total_cnt++;
      if (valid !== tbl[i].e_valid || (tbl[i].e_valid && data !== tbl[i].e_data) ||
          busy !== tbl[i].e_busy || done !== tbl[i].e_done || credit_cnt !== tbl[i].e_cnt ||
          flits_sent !== tbl[i].e_flits || err !== tbl[i].e_err)
        $display("FAIL vec%0d: got v=%b d=%h b=%b dn=%b c=%0d f=%0d e=%b, expected v=%b d=%h b=%b dn=%b c=%0d f=%0d e=%b",
                 i, valid, data, busy, done, credit_cnt, flits_sent, err,
                 tbl[i].e_valid, tbl[i].e_data, tbl[i].e_busy, tbl[i].e_done,
                 tbl[i].e_cnt, tbl[i].e_flits, tbl[i].e_err);
      else pass_cnt++;
    end
    start = 1'b0; credit_upd = 1'b0;

    // Three single-flit packets, gap 2, sink returns each credit in the same cycle
    num_pkts = 16'd3; pkt_len = 8'd1; dst_id = 6'h07; gap = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (valid) begin
        vcyc.push_back(c);
        vdat.push_back(data);
      end
      if (done) seen_done = 1'b1;
      credit_upd = valid;
      tick();
    end
    credit_upd = 1'b0;
    chk("gap_flit_count", 64'(vcyc.size()), 64'd3);
    if (vcyc.size() == 3) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("gap_flit%0d", k), 64'(vdat[k]), 64'(mkflit(2'b11, 6'h07, 10'(k), 8'd0)));
      chk("gap_spacing01", 64'(vcyc[1] - vcyc[0]), 64'd3);
      chk("gap_spacing12", 64'(vcyc[2] - vcyc[1]), 64'd3);
    end
    chk("gap_done_seen", 64'(seen_done), 64'd1);
    chk("gap_credits_end", 64'(credit_cnt), 64'd4);

    // Simultaneous send and credit return, then a send while ready is low
    do_reset();
    num_pkts = 16'd1; pkt_len = 8'd8; dst_id = 6'h15; gap = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_simul_cnt", 64'(credit_cnt), 64'd2);
    credit_upd = 1'b1;
    tick();
    credit_upd = 1'b0;
    chk("simul_cnt", 64'(credit_cnt), 64'd2);
    ready = 1'b0;
    tick();
    ready = 1'b1;
    chk("err_not_ready", 64'(err), 64'b01);

    // Reset in the middle of the packet abandons it
    chk("mid_body_valid", 64'({valid, data[31:30]}), 64'b100);
    rstn = 1'b0;
    tick();
    chk("mid_reset", {valid, busy, credit_cnt, flits_sent, err}, {1'b0, 1'b0, 3'd4, 32'd0, 2'b00});
    rstn = 1'b1;
    tick();
    chk("post_reset_quiet", 64'({valid, busy}), 64'b00);
    num_pkts = 16'd2; pkt_len = 8'd2; dst_id = 6'h3F; gap = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_head", 64'({valid, data}), {31'd0, 1'b1, mkflit(2'b01, 6'h3F, 10'd0, 8'd0)});
    tick();
    chk("restart_tail", 64'({valid, data}), {31'd0, 1'b1, mkflit(2'b10, 6'h3F, 10'd0, 8'd1)});
    tick();
    chk("back2back_head", 64'({valid, data}), {31'd0, 1'b1, mkflit(2'b01, 6'h3F, 10'd1, 8'd0)});

    // num_pkts = 0 goes straight to the done pulse
    do_reset();
    num_pkts = 16'd0; pkt_len = 8'd4; dst_id = 6'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_pkts_fin", 64'({valid, busy, done}), 64'b011);
    tick();
    chk("zero_pkts_idle", 64'({valid, busy, done, flits_sent}), 64'd0);

    // pkt_len = 0 behaves as a single-flit packet
    num_pkts = 16'd1; pkt_len = 8'd0; dst_id = 6'h22;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_single", 64'({valid, data}), {31'd0, 1'b1, mkflit(2'b11, 6'h22, 10'd0, 8'd0)});
    tick();
    chk("len0_done", 64'({valid, done, flits_sent}), {30'd0, 1'b0, 1'b1, 32'd1});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
